// File: rtl/game_pkg.sv
// Shared constants and types for game entity controllers: direction codes,
// register map, control/status bit positions and screen bounds.
package game_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_POS   = 2'd1;
    localparam logic [1:0] ADDR_CFG   = 2'd2;
    localparam logic [1:0] ADDR_IRQEN = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_BLOCKED = 2;

    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } mc_state_e;

    // A programmed speed of 0 behaves as one frame per step.
    function automatic logic [3:0] frames_per_step(input logic [3:0] speed);
        return (speed == 4'd0) ? 4'd1 : speed;
    endfunction

endpackage

// File: rtl/entity_step_calc.sv
// Combinational next-position unit: moves one step along the given direction
// and clamps the sprite so it stays fully on screen.
module entity_step_calc
    import game_pkg::*;
#(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int X_MAX   = SCREEN_X_MAX,
    parameter int Y_MAX   = SCREEN_Y_MAX,
    parameter int SPRITE  = 16,
    parameter int STEP_PX = 2
) (
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    input  logic [1:0]     cur_dir,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny,
    output logic           blocked
);

    // One extra bit so an underflow shows up as the MSB, not a wrapped value.
    localparam logic [X_W:0] X_LIM  = (X_W+1)'(X_MAX - SPRITE + 1);
    localparam logic [Y_W:0] Y_LIM  = (Y_W+1)'(Y_MAX - SPRITE + 1);
    localparam logic [X_W:0] X_STEP = (X_W+1)'(STEP_PX);
    localparam logic [Y_W:0] Y_STEP = (Y_W+1)'(STEP_PX);

    logic [X_W:0] cand_x;
    logic [Y_W:0] cand_y;

    always_comb begin
        nx      = cur_x;
        ny      = cur_y;
        blocked = 1'b0;
        cand_x  = '0;
        cand_y  = '0;
        case (cur_dir)
            DIR_UP: begin
                cand_y = {1'b0, cur_y} - Y_STEP;
                if (cand_y[Y_W]) begin
                    ny      = '0;
                    blocked = 1'b1;
                end else begin
                    ny = cand_y[Y_W-1:0];
                end
            end
            DIR_DOWN: begin
                cand_y = {1'b0, cur_y} + Y_STEP;
                if (cand_y > Y_LIM) begin
                    ny      = Y_LIM[Y_W-1:0];
                    blocked = 1'b1;
                end else begin
                    ny = cand_y[Y_W-1:0];
                end
            end
            DIR_LEFT: begin
                cand_x = {1'b0, cur_x} - X_STEP;
                if (cand_x[X_W]) begin
                    nx      = '0;
                    blocked = 1'b1;
                end else begin
                    nx = cand_x[X_W-1:0];
                end
            end
            DIR_RIGHT: begin
                cand_x = {1'b0, cur_x} + X_STEP;
                if (cand_x > X_LIM) begin
                    nx      = X_LIM[X_W-1:0];
                    blocked = 1'b1;
                end else begin
                    nx = cand_x[X_W-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/entity_motion_ctrl.sv
// Avalon-MM controlled entity mover: steps a sprite in the latched direction,
// paced by frame ticks, with screen clamping and a completion interrupt.
//
// state | meaning
// IDLE  | waiting for start; position writable
// WAIT  | counting frame ticks down to the next step
// STEP  | one cycle: commit next (possibly clamped) position
// DONE  | one cycle: flag completion, raise irq if enabled
module entity_motion_ctrl
    import game_pkg::*;
#(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int X_MAX   = SCREEN_X_MAX,
    parameter int Y_MAX   = SCREEN_Y_MAX,
    parameter int SPRITE  = 16,
    parameter int STEP_PX = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [1:0]     address,
    input  logic           chipselect,
    input  logic           write_n,
    input  logic [31:0]    writedata,
    output logic [31:0]    readdata,
    input  logic [1:0]     dir,
    input  logic           frame_tick,
    output logic [X_W-1:0] ent_x,
    output logic [Y_W-1:0] ent_y,
    output logic [1:0]     anim_frame,
    output logic           moving,
    output logic           irq
);

    mc_state_e      state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [1:0]     anim_q, anim_d;
    logic [1:0]     cur_dir_q, cur_dir_d;
    logic [7:0]     steps_q, steps_d;
    logic [3:0]     speed_q, speed_d;
    logic [7:0]     rem_q, rem_d;
    logic [3:0]     fcnt_q, fcnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           blocked_q, blocked_d;
    logic           irq_q, irq_d;
    logic           irq_en_q, irq_en_d;

    logic           wr_en, start_req, abort_req, clear_req;
    logic [X_W-1:0] step_x;
    logic [Y_W-1:0] step_y;
    logic           step_blocked;
    logic           unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign start_req = wr_en && (address == ADDR_CTRL) && writedata[CTRL_START];
    assign abort_req = wr_en && (address == ADDR_CTRL) && writedata[CTRL_ABORT];
    assign clear_req = wr_en && (address == ADDR_CTRL) && writedata[CTRL_CLEAR];
    assign unused_wd = ^writedata;

    entity_step_calc #(
        .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
        .SPRITE(SPRITE), .STEP_PX(STEP_PX)
    ) u_step_calc (
        .cur_x   (x_q),
        .cur_y   (y_q),
        .cur_dir (cur_dir_q),
        .nx      (step_x),
        .ny      (step_y),
        .blocked (step_blocked)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        anim_d    = anim_q;
        cur_dir_d = cur_dir_q;
        steps_d   = steps_q;
        speed_d   = speed_q;
        rem_d     = rem_q;
        fcnt_d    = fcnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        blocked_d = blocked_q;
        irq_d     = irq_q;
        irq_en_d  = irq_en_q;

        if (wr_en && (address == ADDR_POS) && !busy_q) begin
            x_d = writedata[X_W-1:0];
            y_d = writedata[16 +: Y_W];
        end
        if (wr_en && (address == ADDR_CFG)) begin
            steps_d = writedata[7:0];
            speed_d = writedata[11:8];
        end
        if (wr_en && (address == ADDR_IRQEN)) begin
            irq_en_d = writedata[0];
        end
        // Clear is applied first so a same-cycle DONE set takes priority.
        if (clear_req) begin
            done_d    = 1'b0;
            blocked_d = 1'b0;
            irq_d     = 1'b0;
        end

        if (abort_req) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        cur_dir_d = dir;
                        rem_d     = steps_q;
                        done_d    = 1'b0;
                        blocked_d = 1'b0;
                        busy_d    = 1'b1;
                        if (steps_q == 8'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            fcnt_d  = frames_per_step(speed_q);
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (frame_tick) begin
                        fcnt_d = fcnt_q - 4'd1;
                        if (fcnt_q == 4'd1) state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    x_d    = step_x;
                    y_d    = step_y;
                    anim_d = anim_q + 2'd1;
                    if (step_blocked) begin
                        blocked_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        rem_d = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            fcnt_d  = frames_per_step(speed_q);
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    irq_d   = irq_q | irq_en_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (!irq_en_d) irq_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            anim_q    <= '0;
            cur_dir_q <= '0;
            steps_q   <= '0;
            speed_q   <= '0;
            rem_q     <= '0;
            fcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
            irq_q     <= 1'b0;
            irq_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            anim_q    <= anim_d;
            cur_dir_q <= cur_dir_d;
            steps_q   <= steps_d;
            speed_q   <= speed_d;
            rem_q     <= rem_d;
            fcnt_q    <= fcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            blocked_q <= blocked_d;
            irq_q     <= irq_d;
            irq_en_q  <= irq_en_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[STAT_BUSY]    = busy_q;
                readdata[STAT_DONE]    = done_q;
                readdata[STAT_BLOCKED] = blocked_q;
            end
            ADDR_POS: begin
                readdata[X_W-1:0]  = x_q;
                readdata[16 +: Y_W] = y_q;
            end
            ADDR_CFG: begin
                readdata[7:0]  = steps_q;
                readdata[11:8] = speed_q;
            end
            ADDR_IRQEN: readdata[0] = irq_en_q;
        endcase
    end

    assign ent_x      = x_q;
    assign ent_y      = y_q;
    assign anim_frame = anim_q;
    assign moving     = busy_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_entity_motion_ctrl.sv
// Directed bench for entity_motion_ctrl: register writes, paced moves,
// clamping, abort, ignored inputs and asynchronous reset.
module tb_entity_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  dir;
    logic        frame_tick;
    logic [9:0]  ent_x;
    logic [8:0]  ent_y;
    logic [1:0]  anim_frame;
    logic        moving;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    entity_motion_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .dir        (dir),
        .frame_tick (frame_tick),
        .ent_x      (ent_x),
        .ent_y      (ent_y),
        .anim_frame (anim_frame),
        .moving     (moving),
        .irq        (irq)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic avm_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic avm_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = readdata;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        cyc(3);
    endtask

    function automatic logic [31:0] pos(input int x, input int y);
        return (32'(y) << 16) | 32'(x);
    endfunction

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        dir        = 2'd0;
        frame_tick = 1'b0;
        cyc(3);
        check_val("rst_x", 32'(ent_x), 0);
        check_val("rst_moving", 32'(moving), 0);
        reset_n = 1'b1;
        cyc(1);
        check_val("rst_y", 32'(ent_y), 0);
        check_val("rst_anim", 32'(anim_frame), 0);
        check_val("rst_irq", 32'(irq), 0);
        avm_rd(2'd0, rd_val); check_val("rst_status", rd_val, 0);
        avm_rd(2'd2, rd_val); check_val("rst_cfg", rd_val, 0);
        avm_rd(2'd3, rd_val); check_val("rst_irqen", rd_val, 0);

        // basic move: 3 steps right, 2 frames per step
        avm_wr(2'd1, pos(100, 100));
        avm_wr(2'd2, 32'h0000_0203);
        dir = 2'd3;
        avm_wr(2'd0, 32'h1);
        check_val("basic_busy", 32'(moving), 1);
        tick(); check_val("basic_t1_x", 32'(ent_x), 100);
        tick(); check_val("basic_t2_x", 32'(ent_x), 102);
        tick(); tick(); check_val("basic_t4_x", 32'(ent_x), 104);
        tick(); check_val("basic_t5_x", 32'(ent_x), 104);
        tick(); check_val("basic_t6_x", 32'(ent_x), 106);
        check_val("basic_y", 32'(ent_y), 100);
        check_val("basic_anim", 32'(anim_frame), 3);
        check_val("basic_moving", 32'(moving), 0);
        check_val("basic_irq", 32'(irq), 0);
        avm_rd(2'd0, rd_val); check_val("basic_status", rd_val, 2);
        tick(); tick(); check_val("basic_t8_x", 32'(ent_x), 106);

        // right-edge clamp with irq enabled
        avm_wr(2'd0, 32'h4);
        avm_wr(2'd3, 32'h1);
        avm_wr(2'd1, pos(622, 50));
        avm_wr(2'd2, 32'h0000_0105);
        dir = 2'd3;
        avm_wr(2'd0, 32'h1);
        tick(); check_val("clamp_s1_x", 32'(ent_x), 624);
        check_val("clamp_s1_busy", 32'(moving), 1);
        tick(); check_val("clamp_s2_x", 32'(ent_x), 624);
        check_val("clamp_irq", 32'(irq), 1);
        check_val("clamp_anim_wrap", 32'(anim_frame), 1);
        avm_rd(2'd0, rd_val); check_val("clamp_status", rd_val, 6);
        avm_wr(2'd0, 32'h4);
        check_val("clamp_clr_irq", 32'(irq), 0);
        avm_rd(2'd0, rd_val); check_val("clamp_clr_status", rd_val, 0);

        // top-edge underflow
        avm_wr(2'd1, pos(10, 1));
        avm_wr(2'd2, 32'h0000_0104);
        dir = 2'd0;
        avm_wr(2'd0, 32'h1);
        tick();
        check_val("under_y", 32'(ent_y), 0);
        check_val("under_x", 32'(ent_x), 10);
        check_val("under_moving", 32'(moving), 0);
        avm_rd(2'd0, rd_val); check_val("under_status", rd_val, 6);
        avm_wr(2'd0, 32'h4);

        // abort after two steps left
        avm_wr(2'd1, pos(200, 200));
        avm_wr(2'd2, 32'h0000_010A);
        dir = 2'd2;
        avm_wr(2'd0, 32'h1);
        tick(); tick();
        check_val("abort_x2", 32'(ent_x), 196);
        avm_wr(2'd0, 32'h2);
        check_val("abort_moving", 32'(moving), 0);
        avm_rd(2'd0, rd_val); check_val("abort_status", rd_val, 0);
        tick(); check_val("abort_frozen", 32'(ent_x), 196);
        avm_wr(2'd1, pos(300, 100));
        avm_rd(2'd1, rd_val); check_val("abort_pos_wr", rd_val, pos(300, 100));

        // dir change, POS write and restart during a move are ignored
        avm_wr(2'd1, pos(50, 60));
        avm_wr(2'd2, 32'h0000_0102);
        dir = 2'd1;
        avm_wr(2'd0, 32'h1);
        dir = 2'd2;
        tick();
        check_val("ign_s1_y", 32'(ent_y), 62);
        check_val("ign_s1_x", 32'(ent_x), 50);
        avm_wr(2'd1, pos(0, 0));
        avm_wr(2'd0, 32'h1);
        tick();
        check_val("ign_s2_y", 32'(ent_y), 64);
        check_val("ign_s2_x", 32'(ent_x), 50);
        check_val("ign_moving", 32'(moving), 0);
        tick(); check_val("ign_after_y", 32'(ent_y), 64);

        // zero-step move completes through DONE with no movement
        avm_wr(2'd0, 32'h4);
        avm_wr(2'd2, 32'h0000_0100);
        avm_wr(2'd0, 32'h1);
        check_val("zero_in_done", readdata, 1);
        cyc(1);
        check_val("zero_done", readdata, 2);
        check_val("zero_y", 32'(ent_y), 64);

        // start and abort together: abort wins
        avm_wr(2'd2, 32'h0000_0102);
        avm_wr(2'd0, 32'h3);
        check_val("sa_moving", 32'(moving), 0);
        tick(); check_val("sa_y", 32'(ent_y), 64);

        // asynchronous reset mid-move
        avm_wr(2'd2, 32'h0000_0105);
        dir = 2'd1;
        avm_wr(2'd0, 32'h1);
        tick();
        check_val("rmm_pre_y", 32'(ent_y), 66);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rmm_x", 32'(ent_x), 0);
        check_val("rmm_y", 32'(ent_y), 0);
        check_val("rmm_anim", 32'(anim_frame), 0);
        check_val("rmm_moving", 32'(moving), 0);
        check_val("rmm_irq", 32'(irq), 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        avm_rd(2'd3, rd_val); check_val("rmm_irqen", rd_val, 0);
        avm_rd(2'd2, rd_val); check_val("rmm_cfg", rd_val, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
